// File: rtl/ad7367_responder.sv
// ad7367_responder
// Device-side emulator of the AD7367 dual 14-bit serial ADC.
// - Answers the controller's CNVST / CS / SCLK / ADDR handshake.
// - Returns BUSY plus MSB-first serial data on DOUTA / DOUTB.
// - Results come either from static channel values or from a counter pattern
//   (A = completed-conversion count, B = its complement).
// - All controller inputs are asynchronous to clk. Each one is resynchronised
//   before use, and edges are detected on the synchronised copy.

module ad7367_responder #(
  parameter int CONV_CYCLES = 125,
  parameter int DATA_W      = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CNVST,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              ADDR,
  output logic              BUSY,
  output logic              DOUTA,
  output logic              DOUTB,
  input  logic              pattern_en,
  input  logic [DATA_W-1:0] va1,
  input  logic [DATA_W-1:0] va2,
  input  logic [DATA_W-1:0] vb1,
  input  logic [DATA_W-1:0] vb2,
  output logic [15:0]       conv_count,
  output logic              overrun
);

  // Width of the readout bit counter.
  localparam int BW = $clog2(DATA_W);

  // Conversion timer reload value: BUSY stays high for CONV_CYCLES cycles.
  localparam logic [15:0] CNT_LOAD  = 16'(CONV_CYCLES - 1);
  localparam logic [BW-1:0] BIT_TOP = BW'(DATA_W - 1);

  // Main FSM encoding.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CONVERT = 1'b1;

  // Readout FSM encoding.
  localparam logic [1:0] RD_OFF   = 2'd0;
  localparam logic [1:0] RD_SHIFT = 2'd1;
  localparam logic [1:0] RD_DONE  = 2'd2;

  // Synchroniser bit order: {CNVST, CS, SCLK, ADDR}.
  // ADDR is level-sampled only, so it has no third (edge) stage.
  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [2:0] sync3_r;

  logic cnvst_fall_s;
  logic cs_fall_s;
  logic cs_rise_s;
  logic sclk_fall_s;
  logic cs_low_s;
  logic addr_sync_s;

  logic [0:0]        main_state_r;
  logic [15:0]       conv_cnt_r;
  logic              addr_lat_r;
  logic [DATA_W-1:0] result_a_r;
  logic [DATA_W-1:0] result_b_r;
  logic [DATA_W-1:0] cap_a_s;
  logic [DATA_W-1:0] cap_b_s;

  logic [1:0]        rd_state_r;
  logic [BW-1:0]     bit_cnt_r;
  // Bits below the MSB still to be shifted out; the MSB is driven directly at CS fall.
  logic [DATA_W-2:0] shift_a_r;
  logic [DATA_W-2:0] shift_b_r;

  // Two-flop synchronisers plus an edge-detect stage; lines idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'b1111;
      sync2_r <= 4'b1111;
      sync3_r <= 3'b111;
    end else begin
      sync1_r <= {CNVST, CS, SCLK, ADDR};
      sync2_r <= sync1_r;
      sync3_r <= sync2_r[3:1];
    end
  end

  // Edge and level decode of the synchronised controller lines.
  always_comb begin
    cnvst_fall_s = sync3_r[2] & ~sync2_r[3];
    cs_fall_s    = sync3_r[1] & ~sync2_r[2];
    cs_rise_s    = ~sync3_r[1] & sync2_r[2];
    sclk_fall_s  = sync3_r[0] & ~sync2_r[1];
    cs_low_s     = ~sync2_r[2];
    addr_sync_s  = sync2_r[0];
  end

  // Value captured into the result register when a conversion completes.
  // Pattern mode uses the count before this conversion's increment.
  always_comb begin
    cap_a_s = {DATA_W{1'b0}};
    cap_b_s = {DATA_W{1'b0}};
    if (pattern_en) begin
      cap_a_s = conv_count[DATA_W-1:0];
      cap_b_s = ~conv_count[DATA_W-1:0];
    end else if (addr_lat_r) begin
      cap_a_s = va2;
      cap_b_s = vb2;
    end else begin
      cap_a_s = va1;
      cap_b_s = vb1;
    end
  end

  // Main FSM: start on CNVST fall, time BUSY, then capture and count.
  // A start that lands in CONVERT, including the completion cycle, is only flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_state_r <= ST_IDLE;
      conv_cnt_r   <= 16'd0;
      addr_lat_r   <= 1'b0;
      result_a_r   <= {DATA_W{1'b0}};
      result_b_r   <= {DATA_W{1'b0}};
      BUSY         <= 1'b0;
      conv_count   <= 16'd0;
      overrun      <= 1'b0;
    end else begin
      case (main_state_r)
        ST_IDLE: begin
          if (cnvst_fall_s) begin
            addr_lat_r   <= addr_sync_s;
            conv_cnt_r   <= CNT_LOAD;
            BUSY         <= 1'b1;
            main_state_r <= ST_CONVERT;
          end else begin
            BUSY <= 1'b0;
          end
        end
        ST_CONVERT: begin
          if (cnvst_fall_s) begin
            overrun <= 1'b1;
          end else begin
            overrun <= overrun;
          end
          if (conv_cnt_r == 16'd0) begin
            result_a_r   <= cap_a_s;
            result_b_r   <= cap_b_s;
            BUSY         <= 1'b0;
            conv_count   <= conv_count + 16'd1;
            main_state_r <= ST_IDLE;
          end else begin
            conv_cnt_r <= conv_cnt_r - 16'd1;
          end
        end
        default: begin
          BUSY         <= 1'b0;
          main_state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Readout FSM: CS edges take priority over SCLK.
  // The result word is loaded only at CS fall, so a conversion completing
  // mid-readout leaves the word in flight untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_r <= RD_OFF;
      bit_cnt_r  <= {BW{1'b0}};
      shift_a_r  <= {(DATA_W-1){1'b0}};
      shift_b_r  <= {(DATA_W-1){1'b0}};
      DOUTA      <= 1'b0;
      DOUTB      <= 1'b0;
    end else if (cs_rise_s) begin
      rd_state_r <= RD_OFF;
      DOUTA      <= 1'b0;
      DOUTB      <= 1'b0;
    end else if (cs_fall_s) begin
      shift_a_r  <= result_a_r[DATA_W-2:0];
      shift_b_r  <= result_b_r[DATA_W-2:0];
      DOUTA      <= result_a_r[DATA_W-1];
      DOUTB      <= result_b_r[DATA_W-1];
      bit_cnt_r  <= BIT_TOP;
      rd_state_r <= RD_SHIFT;
    end else begin
      case (rd_state_r)
        RD_OFF: begin
          DOUTA <= 1'b0;
          DOUTB <= 1'b0;
        end
        RD_SHIFT: begin
          if (sclk_fall_s && cs_low_s) begin
            if (bit_cnt_r == {BW{1'b0}}) begin
              DOUTA      <= 1'b0;
              DOUTB      <= 1'b0;
              rd_state_r <= RD_DONE;
            end else begin
              bit_cnt_r <= bit_cnt_r - {{(BW-1){1'b0}}, 1'b1};
              DOUTA     <= shift_a_r[DATA_W-2];
              DOUTB     <= shift_b_r[DATA_W-2];
              shift_a_r <= {shift_a_r[DATA_W-3:0], 1'b0};
              shift_b_r <= {shift_b_r[DATA_W-3:0], 1'b0};
            end
          end else begin
            rd_state_r <= RD_SHIFT;
          end
        end
        RD_DONE: begin
          DOUTA <= 1'b0;
          DOUTB <= 1'b0;
        end
        default: begin
          rd_state_r <= RD_OFF;
          DOUTA      <= 1'b0;
          DOUTB      <= 1'b0;
        end
      endcase
    end
  end

endmodule
